// File: rtl/cpu_pkg.sv
`default_nettype none
// =====================================================================
// cpu_pkg : opcodes, instruction fields and sequencer states
// Rev 1.0
// =====================================================================
package cpu_pkg;

   localparam int WORD_W = 16;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   localparam int OPC_HI = 8;
   localparam int OPC_LO = 6;
   localparam int RX_HI  = 5;
   localparam int RX_LO  = 3;
   localparam int RY_HI  = 2;
   localparam int RY_LO  = 0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_EXEC  = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } seq_state_t;

   function automatic logic [2:0] opcode_of(input logic [WORD_W-1:0] instr);
      return instr[OPC_HI:OPC_LO];
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_prog_sequencer_if.sv
`default_nettype none
// =====================================================================
// cpu_prog_sequencer_if : din/run/done instruction handshake to the CPU
// Rev 1.0
// =====================================================================
interface cpu_prog_sequencer_if;
   import cpu_pkg::*;

   logic              cpu_run;
   logic [WORD_W-1:0] cpu_din;
   logic              cpu_done;

   modport master (output cpu_run, output cpu_din, input  cpu_done);
   modport slave  (input  cpu_run, input  cpu_din, output cpu_done);
endinterface
`default_nettype wire

// File: rtl/prog_mem.sv
`default_nettype none
// =====================================================================
// prog_mem : program register file, sync write, two async read ports
// Rev 1.0
// =====================================================================
module prog_mem
   import cpu_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  wire                clk,
   input  wire                we,
   input  wire [ADDR_W-1:0]   waddr,
   input  wire [WORD_W-1:0]   wdata,
   input  wire [ADDR_W-1:0]   raddr0,
   input  wire [ADDR_W-1:0]   raddr1,
   output logic [WORD_W-1:0]  rdata0,
   output logic [WORD_W-1:0]  rdata1
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];

endmodule
`default_nettype wire

// File: rtl/cpu_prog_sequencer.sv
`default_nettype none
// =====================================================================
// cpu_prog_sequencer : issues a loaded program to the multicycle CPU
// Rev 1.0
// =====================================================================
module cpu_prog_sequencer
   import cpu_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int ADDR_W     = 4,
   parameter int WDOG_LIMIT = 4
) (
   input  wire                  clk,
   input  wire                  resetn,
   input  wire                  load_we,
   input  wire [ADDR_W-1:0]     load_addr,
   input  wire [WORD_W-1:0]     load_data,
   input  wire [ADDR_W:0]       prog_len,
   input  wire                  start,
   cpu_prog_sequencer_if.master cpu,
   output logic                 busy,
   output logic                 finished,
   output logic                 error,
   output logic [ADDR_W:0]      pc,
   output logic [15:0]          instr_count
);

   localparam int WD_W = (WDOG_LIMIT > 1) ? $clog2(WDOG_LIMIT) : 1;

   seq_state_t        state, state_nx;
   logic [ADDR_W:0]   len_q, len_nx, pc_nx, pc_plus1, pc_step;
   logic [15:0]       count_nx;
   logic [WD_W-1:0]   wdog_q, wdog_nx;
   logic [WORD_W-1:0] word_cur, word_imm, din_c;
   logic              run_q, idle_like, mem_we, is_mvi, trunc_mvi;

   assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
   assign mem_we    = load_we && idle_like;
   assign pc_plus1  = pc + (ADDR_W+1)'(1);
   assign is_mvi    = (opcode_of(word_cur) == OP_MVI);
   // An mvi whose immediate lies past the program end cannot be completed
   assign trunc_mvi = is_mvi && (pc_plus1 >= len_q);
   assign pc_step   = is_mvi ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);

   prog_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_prog_mem (
      .clk    (clk),
      .we     (mem_we),
      .waddr  (load_addr),
      .wdata  (load_data),
      .raddr0 (pc[ADDR_W-1:0]),
      .raddr1 (pc_plus1[ADDR_W-1:0]),
      .rdata0 (word_cur),
      .rdata1 (word_imm)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      len_nx   = len_q;
      pc_nx    = pc;
      count_nx = instr_count;
      wdog_nx  = wdog_q;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               len_nx   = prog_len;
               pc_nx    = '0;
               count_nx = '0;
               state_nx = (prog_len == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            wdog_nx  = '0;
            state_nx = trunc_mvi ? S_ERR : S_EXEC;
         end
         S_EXEC: begin
            if (cpu.cpu_done) begin
               count_nx = (instr_count == 16'hFFFF) ? instr_count : instr_count + 16'd1;
               pc_nx    = pc + pc_step;
               state_nx = (pc_nx >= len_q) ? S_DONE : S_ISSUE;
            end else if (wdog_q == WD_W'(WDOG_LIMIT - 1)) begin
               state_nx = S_ERR;
            end else begin
               wdog_nx = wdog_q + WD_W'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they align with it
   always_ff @(posedge clk) begin
      if (!resetn) begin
         len_q       <= '0;
         pc          <= '0;
         instr_count <= '0;
         wdog_q      <= '0;
         run_q       <= 1'b0;
         busy        <= 1'b0;
         finished    <= 1'b0;
         error       <= 1'b0;
      end else begin
         len_q       <= len_nx;
         pc          <= pc_nx;
         instr_count <= count_nx;
         wdog_q      <= wdog_nx;
         run_q       <= (state_nx == S_ISSUE) || (state_nx == S_EXEC);
         busy        <= (state_nx == S_ISSUE) || (state_nx == S_EXEC);
         finished    <= (state_nx == S_DONE);
         error       <= (state_nx == S_ERR);
      end
   end

   always_comb begin
      din_c = '0;
      if (state == S_ISSUE) begin
         din_c = word_cur;
      end else if ((state == S_EXEC) && is_mvi) begin
         din_c = word_imm;
      end
   end

   assign cpu.cpu_run = run_q;
   assign cpu.cpu_din = din_c;

endmodule
`default_nettype wire

// File: tb/tb_cpu_prog_sequencer.sv
`default_nettype none
// =====================================================================
// tb_cpu_prog_sequencer : sequencer driving a behavioural multicycle CPU
// Rev 1.0
// =====================================================================
module tb_cpu_prog_sequencer;
   import cpu_pkg::*;

   logic        clk;
   logic        resetn;
   logic        load_we;
   logic [3:0]  load_addr;
   logic [15:0] load_data;
   logic [4:0]  prog_len;
   logic        start;
   logic        busy, finished, error;
   logic [4:0]  pc;
   logic [15:0] instr_count;

   cpu_prog_sequencer_if cif();

   cpu_prog_sequencer #(
      .DEPTH      (16),
      .ADDR_W     (4),
      .WDOG_LIMIT (4)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .load_we     (load_we),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .prog_len    (prog_len),
      .start       (start),
      .cpu         (cif),
      .busy        (busy),
      .finished    (finished),
      .error       (error),
      .pc          (pc),
      .instr_count (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural CPU ----------------
   logic [15:0] ir = '0, areg = '0, greg = '0, bus_val;
   logic [15:0] regs [8];
   logic [2:0]  step = '0;
   logic [2:0]  op, rx, ry;
   logic        done_raw;
   logic        hold_done;

   initial for (int k = 0; k < 8; k++) regs[k] = '0;

   assign op = ir[OPC_HI:OPC_LO];
   assign rx = ir[RX_HI:RX_LO];
   assign ry = ir[RY_HI:RY_LO];

   always_comb begin
      done_raw = 1'b0;
      bus_val  = '0;
      if (step == 3'd1 && op != OP_ADD && op != OP_SUB) begin
         done_raw = 1'b1;
         bus_val  = (op == OP_MV) ? regs[ry] : (op == OP_MVI) ? cif.cpu_din : 16'h0000;
      end else if (step == 3'd3 && (op == OP_ADD || op == OP_SUB)) begin
         done_raw = 1'b1;
         bus_val  = greg;
      end
   end

   assign cif.cpu_done = done_raw && !hold_done;

   always @(posedge clk) begin
      if (!cif.cpu_run || cif.cpu_done) step <= '0;
      else                              step <= step + 3'd1;
      if (cif.cpu_run) begin
         case (step)
            3'd0: ir <= cif.cpu_din;
            3'd1: begin
               if (op == OP_MV)       regs[rx] <= regs[ry];
               else if (op == OP_MVI) regs[rx] <= cif.cpu_din;
               else if (op == OP_ADD || op == OP_SUB) areg <= regs[rx];
            end
            3'd2: greg <= (op == OP_ADD) ? areg + regs[ry] : areg - regs[ry];
            3'd3: if (op == OP_ADD || op == OP_SUB) regs[rx] <= greg;
            default: ;
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct { logic [4:0] pc; logic [15:0] d0; bit has1; logic [15:0] d1; } iss_t;
   typedef struct { logic [4:0] pc; logic [15:0] bus; } ret_t;
   typedef struct { bit fin; bit err; logic [4:0] pc; logic [15:0] cnt; int rc; int lat; int rises; } end_t;

   iss_t q_iss[$];
   ret_t q_ret[$];
   end_t q_end[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_note(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event not as expected (t=%0t)", name, $time);
   endtask

   task automatic push_iss(input int p, input logic [15:0] d0, input bit h1, input logic [15:0] d1);
      iss_t r;
      r.pc = p[4:0]; r.d0 = d0; r.has1 = h1; r.d1 = d1;
      q_iss.push_back(r);
   endtask

   task automatic push_ret(input int p, input logic [15:0] b);
      ret_t r;
      r.pc = p[4:0]; r.bus = b;
      q_ret.push_back(r);
   endtask

   task automatic push_end(input bit f, input bit e, input int p, input int c,
                           input int rc, input int lat, input int rises);
      end_t r;
      r.fin = f; r.err = e; r.pc = p[4:0]; r.cnt = c[15:0]; r.rc = rc; r.lat = lat; r.rises = rises;
      q_end.push_back(r);
   endtask

   int          since = 0, runcyc = 0, rises = 0;
   bit          prev_run = 0, prev_fin = 0, prev_err = 0, pend1 = 0;
   logic [15:0] pend_d1 = '0;
   iss_t        mi;
   ret_t        mr;
   end_t        me;

   always @(negedge clk) begin
      if (start && !busy) begin
         since = 0; runcyc = 0; rises = 0;
      end else begin
         since++;
         if (cif.cpu_run) runcyc++;
         if (cif.cpu_run && !prev_run) rises++;
      end
      prev_run = cif.cpu_run;

      if (pend1 && cif.cpu_run && step == 3'd1) begin
         check("exec_din", cif.cpu_din, pend_d1);
         pend1 = 0;
      end
      if (cif.cpu_run && step == 3'd0) begin
         if (q_iss.size() == 0) fail_note("unexpected_issue");
         else begin
            mi = q_iss.pop_front();
            check("issue_pc", pc, mi.pc);
            check("issue_din", cif.cpu_din, mi.d0);
            pend1   = mi.has1;
            pend_d1 = mi.d1;
         end
      end
      if (cif.cpu_run && cif.cpu_done) begin
         if (q_ret.size() == 0) fail_note("unexpected_retire");
         else begin
            mr = q_ret.pop_front();
            check("retire_pc", pc, mr.pc);
            check("retire_bus", bus_val, mr.bus);
         end
      end
      if ((finished && !prev_fin) || (error && !prev_err)) begin
         if (q_end.size() == 0) fail_note("unexpected_end");
         else begin
            me = q_end.pop_front();
            check("end_finished", finished, me.fin);
            check("end_error", error, me.err);
            check("end_pc", pc, me.pc);
            check("end_count", instr_count, me.cnt);
            check("end_run_low", cif.cpu_run, 0);
            check("end_run_cycles", runcyc, me.rc);
            check("end_latency", since, me.lat);
            check("end_run_rises", rises, me.rises);
         end
      end
      prev_fin = finished;
      prev_err = error;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input logic [15:0] d);
      load_we = 1'b1; load_addr = a[3:0]; load_data = d;
      tick();
      load_we = 1'b0;
   endtask

   task automatic load_basic();
      load(0, 16'h0040); load(1, 16'h0005); load(2, 16'h0048);
      load(3, 16'h0003); load(4, 16'h0081); load(5, 16'h0010);
   endtask

   // mvi r0,#5 ; mvi r1,#3 ; add r0,r1 ; mv r2,r0
   task automatic push_basic(input bit with_end);
      push_iss(0, 16'h0040, 1, 16'h0005); push_ret(0, 16'h0005);
      push_iss(2, 16'h0048, 1, 16'h0003); push_ret(2, 16'h0003);
      push_iss(4, 16'h0081, 1, 16'h0000); push_ret(4, 16'h0008);
      push_iss(5, 16'h0010, 1, 16'h0000); push_ret(5, 16'h0008);
      if (with_end) push_end(1, 0, 6, 4, 10, 11, 1);
   endtask

   task automatic start_prog(input logic [4:0] len);
      prog_len = len; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_end(input int budget);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         if (finished || error) begin seen = 1; break; end
         tick();
      end
      if (!seen) fail_note("end_timeout");
      tick(); tick();
   endtask

   initial begin
      bit hit;
      resetn = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
      prog_len = '0; start = 1'b0; hold_done = 1'b0;
      repeat (3) tick();
      check("rst_run", cif.cpu_run, 0);
      check("rst_din", cif.cpu_din, 0);
      check("rst_busy", busy, 0);
      check("rst_finished", finished, 0);
      check("rst_error", error, 0);
      check("rst_pc", pc, 0);
      check("rst_count", instr_count, 0);
      resetn = 1'b1;
      tick();

      load_basic(); push_basic(1);
      start_prog(5'd6); wait_end(40);

      load(0, 16'h0040); load(1, 16'h1234);
      push_iss(0, 16'h0040, 1, 16'h1234); push_ret(0, 16'h1234);
      push_end(1, 0, 2, 1, 2, 3, 1);
      start_prog(5'd2); wait_end(40);

      hold_done = 1'b1;
      load(0, 16'h0081);
      push_iss(0, 16'h0081, 1, 16'h0000);
      push_end(0, 1, 0, 0, 5, 6, 1);
      start_prog(5'd1); wait_end(40);
      hold_done = 1'b0;

      load(0, 16'h0040);
      push_iss(0, 16'h0040, 0, 16'h0000);
      push_end(0, 1, 0, 0, 1, 2, 1);
      start_prog(5'd1); wait_end(40);

      push_end(1, 0, 0, 0, 0, 1, 0);
      start_prog(5'd0); wait_end(40);

      // Write and restart attempted mid-run must leave run and memory intact
      load_basic(); push_basic(1);
      start_prog(5'd6);
      tick(); tick();
      load_we = 1'b1; load_addr = 4'd3; load_data = 16'hFFFF; start = 1'b1; prog_len = 5'd0;
      tick();
      load_we = 1'b0; start = 1'b0;
      wait_end(40);
      push_basic(1);
      start_prog(5'd6); wait_end(40);

      // Reset while the add sits in CPU step 2
      push_iss(0, 16'h0040, 1, 16'h0005); push_ret(0, 16'h0005);
      push_iss(2, 16'h0048, 1, 16'h0003); push_ret(2, 16'h0003);
      push_iss(4, 16'h0081, 1, 16'h0000);
      start_prog(5'd6);
      hit = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cif.cpu_run && step == 3'd2) begin hit = 1; break; end
      end
      if (!hit) fail_note("add_step2_timeout");
      resetn = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_run", cif.cpu_run, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_pc", pc, 0);
      check("mid_rst_count", instr_count, 0);
      resetn = 1'b1;
      tick(); tick(); tick();

      check("iss_queue_left", q_iss.size(), 0);
      check("ret_queue_left", q_ret.size(), 0);
      check("end_queue_left", q_end.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
